// File: rtl/td4_pkg.sv
// Shared TD4 types: destination select, execution FSM states, default width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package td4_pkg;

  localparam int TD4_W = 4;

  // Destination register select, shared with the decoder and source selector.
  typedef enum logic [1:0] {
    DST_A   = 2'b00,
    DST_B   = 2'b01,
    DST_OUT = 2'b10,
    DST_PC  = 2'b11
  } dst_e;

  // Execution control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } exec_st_e;

endpackage

// File: rtl/td4_regbank_if.sv
// Write-back bus between ALU/decoder side and the TD4 register bank.
// Latency: n/a (wires only).
// Backpressure: none; the bank commits whenever exec is high.
// Ports: master drives d/cout/ld_sel/ld_en/run/step and observes the registers;
//        slave (the bank) drives ra/rb/rout/pc/c_flag/exec.
interface td4_regbank_if
  import td4_pkg::*;
#(
  parameter int W = TD4_W
);
  logic [W-1:0] d;
  logic         cout;
  dst_e         ld_sel;
  logic         ld_en;
  logic         run;
  logic         step;
  logic [W-1:0] ra;
  logic [W-1:0] rb;
  logic [W-1:0] rout;
  logic [W-1:0] pc;
  logic         c_flag;
  logic         exec;

  modport master (
    output d, cout, ld_sel, ld_en, run, step,
    input  ra, rb, rout, pc, c_flag, exec
  );

  modport slave (
    input  d, cout, ld_sel, ld_en, run, step,
    output ra, rb, rout, pc, c_flag, exec
  );
endinterface

// File: rtl/td4_step_ctrl.sv
// Run / single-step execution control FSM (IDLE, RUN, STEP).
// Latency: exec rises the cycle after IDLE samples run or step; STEP lasts one cycle.
// Backpressure: none; step pulses arriving in RUN or STEP are dropped.
// Ports: clk, rst_n (async active-low), run (level), step (pulse) -> exec.
module td4_step_ctrl
  import td4_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic step,
  output logic exec
);

  exec_st_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        // run has priority over step when both are present.
        if (run)       state_d = ST_RUN;
        else if (step) state_d = ST_STEP;
      end
      ST_RUN:  if (!run) state_d = ST_IDLE;
      ST_STEP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    exec = (state_q == ST_RUN) || (state_q == ST_STEP);
  end

endmodule

// File: rtl/td4_regbank.sv
// TD4 register bank: A, B, OUT, PC and carry flag, written from the ALU result.
// Latency: a commit at edge n is visible on the outputs in cycle n+1 (no bypass).
// Backpressure: none; all state holds while exec is low.
// Ports: clk, rst_n (async active-low), bus (slave modport of td4_regbank_if).
module td4_regbank
  import td4_pkg::*;
#(
  parameter int           W      = TD4_W,
  parameter logic [W-1:0] PC_RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  td4_regbank_if.slave bus
);

  logic         exec;
  logic [W-1:0] ra_q, ra_d;
  logic [W-1:0] rb_q, rb_d;
  logic [W-1:0] rout_q, rout_d;
  logic [W-1:0] pc_q, pc_d;
  logic         c_flag_q, c_flag_d;

  td4_step_ctrl u_step_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (bus.run),
    .step  (bus.step),
    .exec  (exec)
  );

  always_comb begin
    ra_d     = ra_q;
    rb_d     = rb_q;
    rout_d   = rout_q;
    pc_d     = pc_q;
    c_flag_d = c_flag_q;
    if (exec) begin
      // Carry follows the ALU on every commit, even when nothing is loaded.
      c_flag_d = bus.cout;
      // Default sequential fetch; wraps naturally at 2^W.
      pc_d     = pc_q + W'(1);
      if (bus.ld_en) begin
        case (bus.ld_sel)
          DST_A:   ra_d   = bus.d;
          DST_B:   rb_d   = bus.d;
          DST_OUT: rout_d = bus.d;
          DST_PC:  pc_d   = bus.d;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra_q     <= '0;
      rb_q     <= '0;
      rout_q   <= '0;
      pc_q     <= PC_RST;
      c_flag_q <= 1'b0;
    end else begin
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      rout_q   <= rout_d;
      pc_q     <= pc_d;
      c_flag_q <= c_flag_d;
    end
  end

  assign bus.ra     = ra_q;
  assign bus.rb     = rb_q;
  assign bus.rout   = rout_q;
  assign bus.pc     = pc_q;
  assign bus.c_flag = c_flag_q;
  assign bus.exec   = exec;

endmodule

// File: tb/tb_td4_regbank.sv
// Directed bench for td4_regbank: loads, jump/wrap, carry, single step, run/stop, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_td4_regbank;
  import td4_pkg::*;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  int   n_exec;

  td4_regbank_if #(.W(4)) bus_if ();

  td4_regbank #(.W(4), .PC_RST(4'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle 1ns so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input dst_e sel, input logic [3:0] dv, input logic co);
    bus_if.ld_en  = en;
    bus_if.ld_sel = sel;
    bus_if.d      = dv;
    bus_if.cout   = co;
  endtask

  task automatic check_regs(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] o, input logic [3:0] p);
    check({tag, ".ra"},   32'(bus_if.ra),   32'(a));
    check({tag, ".rb"},   32'(bus_if.rb),   32'(b));
    check({tag, ".rout"}, 32'(bus_if.rout), 32'(o));
    check({tag, ".pc"},   32'(bus_if.pc),   32'(p));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    n_exec = 0;
    rst_n  = 1'b0;
    bus_if.run  = 1'b0;
    bus_if.step = 1'b0;
    drive(1'b0, DST_A, 4'h0, 1'b0);

    // Reset state, before any clock edge.
    #2;
    check_regs("rst0", 4'h0, 4'h0, 4'h0, 4'h0);
    check("rst0.c",    32'(bus_if.c_flag), 32'd0);
    check("rst0.exec", 32'(bus_if.exec),   32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("idle.exec", 32'(bus_if.exec), 32'd0);

    // Load each destination while running.
    bus_if.run = 1'b1;
    drive(1'b1, DST_A, 4'h5, 1'b0);
    tick();
    check("start.exec", 32'(bus_if.exec), 32'd1);
    check_regs("start", 4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    check_regs("ldA", 4'h5, 4'h0, 4'h0, 4'h1);
    drive(1'b1, DST_B, 4'hA, 1'b0);
    tick();
    check_regs("ldB", 4'h5, 4'hA, 4'h0, 4'h2);
    drive(1'b1, DST_OUT, 4'h3, 1'b0);
    tick();
    check_regs("ldOUT", 4'h5, 4'hA, 4'h3, 4'h3);

    // Jump to E, then increment through F and wrap to 0 without touching carry.
    drive(1'b1, DST_PC, 4'hE, 1'b0);
    tick();
    check_regs("jmpE", 4'h5, 4'hA, 4'h3, 4'hE);
    drive(1'b0, DST_PC, 4'h1, 1'b0);
    tick();
    check_regs("incF", 4'h5, 4'hA, 4'h3, 4'hF);
    tick();
    check_regs("wrap", 4'h5, 4'hA, 4'h3, 4'h0);
    check("wrap.c", 32'(bus_if.c_flag), 32'd0);

    // Conditional no-load at pc=4 with carry in; run drops on the same cycle.
    drive(1'b1, DST_PC, 4'h4, 1'b0);
    tick();
    check("jmp4.pc", 32'(bus_if.pc), 32'h4);
    drive(1'b0, DST_PC, 4'h7, 1'b1);
    bus_if.run = 1'b0;
    tick();
    check("jnc.pc",   32'(bus_if.pc),     32'h5);
    check("jnc.c",    32'(bus_if.c_flag), 32'd1);
    check("jnc.exec", 32'(bus_if.exec),   32'd0);

    // Idle: inputs are don't-care, everything holds.
    drive(1'b1, DST_A, 4'hF, 1'b0);
    tick();
    check_regs("hold", 4'h5, 4'hA, 4'h3, 4'h5);
    check("hold.c", 32'(bus_if.c_flag), 32'd1);

    // Single step, with a second step pulse during the STEP cycle.
    drive(1'b1, DST_A, 4'h9, 1'b0);
    bus_if.step = 1'b1;
    tick();
    check("step.exec", 32'(bus_if.exec), 32'd1);
    check("step.pre",  32'(bus_if.ra),   32'h5);
    tick();
    bus_if.step = 1'b0;
    check("step.exec_lo", 32'(bus_if.exec),   32'd0);
    check_regs("step", 4'h9, 4'hA, 4'h3, 4'h6);
    check("step.c", 32'(bus_if.c_flag), 32'd0);
    tick();
    check("step2.exec", 32'(bus_if.exec), 32'd0);
    check("step2.pc",   32'(bus_if.pc),   32'h6);

    // Run for five sampled cycles with a step pulse in the middle.
    drive(1'b0, DST_A, 4'h0, 1'b0);
    bus_if.run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus_if.step = (i == 2);
      tick();
      if (bus_if.exec) n_exec++;
    end
    bus_if.run  = 1'b0;
    bus_if.step = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus_if.exec) n_exec++;
    end
    check("run.exec_cnt", 32'(n_exec),      32'd5);
    check("run.pc",       32'(bus_if.pc),   32'hB);
    check("run.ra",       32'(bus_if.ra),   32'h9);

    // Reset mid-cycle while running with registers nonzero.
    bus_if.run = 1'b1;
    drive(1'b1, DST_B, 4'h7, 1'b1);
    tick();
    check("pre_rst.exec", 32'(bus_if.exec), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_regs("rst1", 4'h0, 4'h0, 4'h0, 4'h0);
    check("rst1.c",    32'(bus_if.c_flag), 32'd0);
    check("rst1.exec", 32'(bus_if.exec),   32'd0);
    bus_if.run = 1'b0;
    tick();
    check("rst1.hold_pc", 32'(bus_if.pc), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/td4_regbank.md
# td4_regbank

Write-side companion to the TD4 source selector: takes the ALU result and distributes it to one of four architectural registers (A, B, OUT, PC). Also owns the program counter increment, the carry flag, and a run/single-step execution control. Sits between the ALU output and the register inputs of the 4-bit TD4 core, and feeds A, B, PC and the carry flag back to the selector and decoder.

## Interface

Parameters:
- `W`, 4, datapath width; all registers and PC.
- `PC_RST`, 0, PC value after reset.

Ports:
- `clk`  in  1  core clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `d`  in  W  ALU result to be written.
- `cout`  in  1  ALU carry-out of the current instruction.
- `ld_sel`  in  2  destination: 00 A, 01 B, 10 OUT, 11 PC.
- `ld_en`  in  1  destination write enable (0 = no write, e.g. JNC with carry set).
- `run`  in  1  level; 1 = free-running execution.
- `step`  in  1  single-cycle pulse (already debounced) requesting one instruction while stopped.
- `ra`, `rb`  out  W  register A, register B.
- `rout`  out  W  output port register.
- `pc`  out  W  program counter.
- `c_flag`  out  1  carry flag.
- `exec`  out  1  1 in cycles in which an instruction commits.

## Operation

- Execution FSM, 3 states:
  - IDLE: `exec`=0; `run`=1 → RUN; else `step`=1 → STEP.
  - RUN: `exec`=1; `run`=0 → IDLE.
  - STEP: `exec`=1 for exactly one cycle → IDLE unconditionally; `run` and `step` are ignored in STEP.
- `exec` is a combinational decode of state (RUN or STEP).
- In a cycle with `exec`=1:
  - If `ld_en`=1, the register selected by `ld_sel` loads `d`. All other registers hold.
  - PC:
    - If `ld_en`=1 and `ld_sel`=11, PC loads `d` (jump).
    - Otherwise PC increments by 1 modulo 2^W (0xF → 0x0 for W=4).
  - `c_flag` loads `cout` regardless of `ld_en`.
- In a cycle with `exec`=0, all registers, PC and `c_flag` hold; `d`, `cout`, `ld_sel` and `ld_en` are don't-care.
- Only one register is written per instruction. There is no bypass: a value written in cycle n appears on outputs in cycle n+1.
- `step` pulses while in RUN or STEP are dropped, not queued.

## Timing

- Reset (`rst_n`=0, asynchronous): state=IDLE, `ra`=`rb`=`rout`=0, `pc`=`PC_RST`, `c_flag`=0, `exec`=0. Outputs are valid immediately, without a clock edge.
- Reset deassertion is taken at the next rising edge. First possible `exec`=1 is the cycle after IDLE samples `run` or `step`.
- Latency:
  - IDLE with `run`=1 at edge k: RUN from k, first commit at edge k+1.
  - `step` pulse sampled at edge k: exactly one commit at edge k+1, then IDLE.
  - `run` falling sampled at edge k: no commit at edge k+1.
- Reset asserted mid-instruction: the in-flight commit is discarded; all state goes to reset values.
- PC wrap: an increment at 0xF yields 0x0 and does not touch `c_flag`. Only `cout` drives the carry flag.

## Structure

- Shared package `td4_pkg`:
  - `dst_e` enum {DST_A=2'b00, DST_B=2'b01, DST_OUT=2'b10, DST_PC=2'b11}, shared with the decoder and the selector.
  - `exec_st_e` enum {ST_IDLE, ST_RUN, ST_STEP}.
  - Default width constant `TD4_W`=4.
- One sub-module, `td4_step_ctrl`: the 3-state FSM. Inputs `clk`, `rst_n`, `run`, `step`; output `exec`.
- The top level holds the register bank, the write decode and the PC incrementer.

## Test plan

- Reset check: pulse `rst_n` low mid-clock with registers nonzero → all outputs 0, `pc`=PC_RST, `exec`=0 with no clock edge.
- Load each destination: RUN, `ld_en`=1, `ld_sel`=00/01/10 with `d`=5/A/3 on successive cycles → `ra`=5, `rb`=A, `rout`=3; `pc` advances 0→1→2→3; untouched registers hold.
- Jump and wrap:
  - `ld_sel`=11, `d`=E → `pc`=E.
  - Next two cycles with `ld_en`=0 → `pc`=F, then 0.
  - `ra`, `rb`, `rout` unchanged throughout.
- Conditional no-load: `ld_sel`=11, `ld_en`=0, `d`=7, `cout`=1 at `pc`=4 → `pc`=5 (no jump), `c_flag`=1.
- Single step: IDLE, `step` pulse with `ld_sel`=00, `d`=9 → exactly one commit (`ra`=9, `pc`+1), `exec` high for one cycle. A second `step` pulse during that STEP cycle is ignored.
- Run/stop: `run`=1 for 5 cycles then 0 → `pc` advances by exactly 5 (including the start-up cycle), then holds. A `step` pulse while `run`=1 adds no extra commit.
